// File: rtl/uart_prog_loader_if.sv
// Byte-stream and memory-write bus between the UART program loader and its surroundings.
// master: the loader side; slave: the UART/BRAM side.
interface uart_prog_loader_if #(
  parameter int unsigned ADDR_WIDTH = 11
) ();
  logic [7:0]            rx_data;
  logic                  rx_data_wr;
  logic                  tx_ready;
  logic [7:0]            tx_data;
  logic                  tx_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wr_data;
  logic                  mem_wr;

  modport master (
    input  rx_data, rx_data_wr, tx_ready,
    output tx_data, tx_en, mem_addr, mem_wr_data, mem_wr
  );

  modport slave (
    output rx_data, rx_data_wr, tx_ready,
    input  tx_data, tx_en, mem_addr, mem_wr_data, mem_wr
  );
endinterface

// File: rtl/uart_prog_loader.sv
// Loads a 0xFFFF-terminated big-endian word image from UART into BRAM, then releases the CPU.
// Optional macro LOADER_CHECKSUM_EN: a two's-complement checksum byte must follow the terminator.
module uart_prog_loader #(
  parameter int unsigned           ADDR_WIDTH  = 11,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 11'h200,
  parameter int unsigned           TIMEOUT_CYC = 2700000,
  parameter logic [7:0]            ACK_BYTE    = 8'h06,
  parameter logic [7:0]            NAK_BYTE    = 8'h15
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    restart,
  uart_prog_loader_if.master      bus,
  output logic                    load_done,
  output logic                    load_err,
  output logic [ADDR_WIDTH-2:0]   word_count,
  output logic [15:0]             uart_word,
  output logic                    uart_word_v
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned WC_W  = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    LOAD_HI = 3'd0,
    LOAD_LO = 3'd1,
    WRITE   = 3'd2,
    ACK     = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
`ifdef LOADER_CHECKSUM_EN
    , CHK   = 3'd6
`endif
  } state_t;

  state_t           state;
  logic [7:0]       hi_byte;
  logic [CNT_W-1:0] idle_cnt;
  logic             phase;
  logic             nak_sent;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  logic timed_c;
  logic timeout_c;

  // Idle timer runs only while half a word (or the checksum byte) is outstanding
  always_comb begin
    timed_c = (state == LOAD_LO) || ((state == DONE) && phase);
`ifdef LOADER_CHECKSUM_EN
    timed_c = timed_c || (state == CHK);
`endif
    timeout_c = timed_c && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= LOAD_HI;
      hi_byte         <= '0;
      idle_cnt        <= '0;
      phase           <= 1'b0;
      nak_sent        <= 1'b0;
      bus.mem_addr    <= BASE_ADDR;
      bus.mem_wr_data <= '0;
      bus.mem_wr      <= 1'b0;
      bus.tx_data     <= '0;
      bus.tx_en       <= 1'b0;
      load_done       <= 1'b0;
      load_err        <= 1'b0;
      word_count      <= '0;
      uart_word       <= '0;
      uart_word_v     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum             <= '0;
`endif
    end else if (restart) begin
      // tx_data keeps its last value; a coincident rx byte is dropped
      state           <= LOAD_HI;
      hi_byte         <= '0;
      idle_cnt        <= '0;
      phase           <= 1'b0;
      nak_sent        <= 1'b0;
      bus.mem_addr    <= BASE_ADDR;
      bus.mem_wr_data <= '0;
      bus.mem_wr      <= 1'b0;
      bus.tx_en       <= 1'b0;
      load_done       <= 1'b0;
      load_err        <= 1'b0;
      word_count      <= '0;
      uart_word       <= '0;
      uart_word_v     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum             <= '0;
`endif
    end else begin
      bus.mem_wr  <= 1'b0;
      bus.tx_en   <= 1'b0;
      uart_word_v <= 1'b0;
      idle_cnt    <= (timed_c && !bus.rx_data_wr && !timeout_c) ? idle_cnt + CNT_W'(1) : '0;

      case (state)
        LOAD_HI: begin
          if (bus.rx_data_wr) begin
            hi_byte <= bus.rx_data;
            state   <= LOAD_LO;
          end
        end

        LOAD_LO: begin
          if (bus.rx_data_wr) begin
            if ({hi_byte, bus.rx_data} == 16'hFFFF) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= ACK;
`endif
            end else begin
              bus.mem_wr_data <= {hi_byte, bus.rx_data};
              bus.mem_wr      <= 1'b1;
              state           <= WRITE;
`ifdef LOADER_CHECKSUM_EN
              sum             <= sum + hi_byte + bus.rx_data;
`endif
            end
          end else if (timeout_c) begin
            hi_byte <= '0;
            state   <= LOAD_HI;
          end
        end

        // Write strobe is on the bus this cycle; advance, or stop at the last word
        WRITE: begin
          word_count <= word_count + WC_W'(1);
          if (bus.mem_addr == LAST_ADDR) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(2);
            if (bus.rx_data_wr) begin
              hi_byte <= bus.rx_data;
              state   <= LOAD_LO;
            end else begin
              state <= LOAD_HI;
            end
          end
        end

        ACK: begin
          if (bus.tx_ready) begin
            bus.tx_data <= ACK_BYTE;
            bus.tx_en   <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          load_done <= 1'b1;
          if (bus.rx_data_wr) begin
            if (phase) begin
              uart_word   <= {hi_byte, bus.rx_data};
              uart_word_v <= 1'b1;
              phase       <= 1'b0;
            end else begin
              hi_byte <= bus.rx_data;
              phase   <= 1'b1;
            end
          end else if (timeout_c) begin
            phase <= 1'b0;
          end
        end

        ERR: begin
          load_err <= 1'b1;
          if (!nak_sent && bus.tx_ready) begin
            bus.tx_data <= NAK_BYTE;
            bus.tx_en   <= 1'b1;
            nak_sent    <= 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (bus.rx_data_wr) begin
            if (8'(sum + bus.rx_data) == 8'h00) begin
              state <= ACK;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end else if (timeout_c) begin
            state    <= ERR;
            load_err <= 1'b1;
          end
        end
`endif

        default: state <= LOAD_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: a default-width loader and a 4-bit-address loader for overflow.
module tb_uart_prog_loader;

  localparam int unsigned T = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic restart_a, restart_b;

  always #5 clk = ~clk;

  uart_prog_loader_if #(.ADDR_WIDTH(11)) ifa ();
  uart_prog_loader_if #(.ADDR_WIDTH(4))  ifb ();

  logic        load_done_a, load_err_a, uart_word_v_a;
  logic [9:0]  word_count_a;
  logic [15:0] uart_word_a;
  logic        load_done_b, load_err_b, uart_word_v_b;
  logic [2:0]  word_count_b;
  logic [15:0] uart_word_b;

  uart_prog_loader #(.ADDR_WIDTH(11), .BASE_ADDR(11'h200), .TIMEOUT_CYC(T)) u_a (
    .sys_clk(clk), .rst_n(rst_n), .restart(restart_a), .bus(ifa),
    .load_done(load_done_a), .load_err(load_err_a), .word_count(word_count_a),
    .uart_word(uart_word_a), .uart_word_v(uart_word_v_a)
  );

  uart_prog_loader #(.ADDR_WIDTH(4), .BASE_ADDR(4'hC), .TIMEOUT_CYC(T)) u_b (
    .sys_clk(clk), .rst_n(rst_n), .restart(restart_b), .bus(ifb),
    .load_done(load_done_b), .load_err(load_err_b), .word_count(word_count_b),
    .uart_word(uart_word_b), .uart_word_v(uart_word_v_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int tx_seen_a = 0;
  int tx_seen_b = 0;

  logic [31:0] exp_mem_a[$], exp_mem_b[$];
  logic [7:0]  exp_tx_a[$],  exp_tx_b[$];
  logic [15:0] exp_word_a[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: unexpected event with value 0x%0h, none expected", name, act);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a write, a tx byte or a word
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.mem_wr) begin
        if (exp_mem_a.size() == 0) unexpected("a_mem_wr", {16'(ifa.mem_addr), ifa.mem_wr_data});
        else chk("a_mem_wr", {16'(ifa.mem_addr), ifa.mem_wr_data}, exp_mem_a.pop_front());
      end
      if (ifb.mem_wr) begin
        if (exp_mem_b.size() == 0) unexpected("b_mem_wr", {16'(ifb.mem_addr), ifb.mem_wr_data});
        else chk("b_mem_wr", {16'(ifb.mem_addr), ifb.mem_wr_data}, exp_mem_b.pop_front());
      end
      if (ifa.tx_en) begin
        tx_seen_a++;
        if (!ifa.tx_ready) unexpected("a_tx_en_not_ready", 32'(ifa.tx_data));
        if (exp_tx_a.size() == 0) unexpected("a_tx", 32'(ifa.tx_data));
        else chk("a_tx", 32'(ifa.tx_data), 32'(exp_tx_a.pop_front()));
      end
      if (ifb.tx_en) begin
        tx_seen_b++;
        if (exp_tx_b.size() == 0) unexpected("b_tx", 32'(ifb.tx_data));
        else chk("b_tx", 32'(ifb.tx_data), 32'(exp_tx_b.pop_front()));
      end
      if (uart_word_v_a) begin
        if (exp_word_a.size() == 0) unexpected("a_uart_word", 32'(uart_word_a));
        else chk("a_uart_word", 32'(uart_word_a), 32'(exp_word_a.pop_front()));
      end
      if (uart_word_v_b) unexpected("b_uart_word", 32'(uart_word_b));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One-cycle strobe; consecutive calls give back-to-back bytes
  task automatic send_byte(input int which, input logic [7:0] b);
    if (which == 0) begin
      ifa.rx_data = b; ifa.rx_data_wr = 1'b1;
    end else begin
      ifb.rx_data = b; ifb.rx_data_wr = 1'b1;
    end
    @(posedge clk); #1;
    ifa.rx_data_wr = 1'b0;
    ifb.rx_data_wr = 1'b0;
  endtask

  task automatic send_term(input int which, input logic [7:0] csum);
    send_byte(which, 8'hFF);
    send_byte(which, 8'hFF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(which, csum);
`else
    if (csum === 8'hxx) $display("note: checksum byte undefined");
`endif
  endtask

  task automatic pulse_restart_a(input logic [7:0] b);
    restart_a = 1'b1; ifa.rx_data = b; ifa.rx_data_wr = 1'b1;
    @(posedge clk); #1;
    restart_a = 1'b0; ifa.rx_data_wr = 1'b0;
  endtask

  int tx_before;

  initial begin
    rst_n = 1'b0; restart_a = 1'b0; restart_b = 1'b0;
    ifa.rx_data = '0; ifa.rx_data_wr = 1'b0; ifa.tx_ready = 1'b1;
    ifb.rx_data = '0; ifb.rx_data_wr = 1'b0; ifb.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk("rst_a_addr", 32'(ifa.mem_addr), 32'h200);
    chk("rst_b_addr", 32'(ifb.mem_addr), 32'hC);
    chk("rst_a_done", 32'(load_done_a), 32'h0);
    chk("rst_a_err", 32'(load_err_a), 32'h0);
    chk("rst_a_wc", 32'(word_count_a), 32'h0);
    chk("rst_a_wr", 32'(ifa.mem_wr), 32'h0);
    chk("rst_a_txen", 32'(ifa.tx_en), 32'h0);
    chk("rst_a_txdata", 32'(ifa.tx_data), 32'h0);
    chk("rst_a_uword", 32'(uart_word_a), 32'h0);

    rst_n = 1'b1;
    idle(2);

    // Back-to-back load: the third byte lands during WRITE
    exp_mem_a.push_back({16'h0200, 16'h1234});
    exp_mem_a.push_back({16'h0202, 16'hABCD});
    exp_tx_a.push_back(8'h06);
    send_byte(0, 8'h12); send_byte(0, 8'h34);
    send_byte(0, 8'hAB); send_byte(0, 8'hCD);
    send_term(0, 8'h42);
    idle(5);
    chk("t1_wc", 32'(word_count_a), 32'd2);
    chk("t1_done", 32'(load_done_a), 32'h1);
    chk("t1_addr", 32'(ifa.mem_addr), 32'h204);
    chk("t1_tx_cnt", 32'(tx_seen_a), 32'd1);

    // DONE: word forwarding, no memory writes, half-pair timeout
    exp_word_a.push_back(16'h002A);
    send_byte(0, 8'h00); send_byte(0, 8'h2A);
    idle(3);
    chk("t3_uword", 32'(uart_word_a), 32'h002A);
    exp_word_a.push_back(16'h002B);
    send_byte(0, 8'h55);
    idle(T + 5);
    send_byte(0, 8'h00); send_byte(0, 8'h2B);
    idle(3);
    chk("t3_uword_to", 32'(uart_word_a), 32'h002B);
    chk("t3_done_hold", 32'(load_done_a), 32'h1);

    // Restart with a coincident byte, which must be dropped
    pulse_restart_a(8'h77);
    chk("rs_done", 32'(load_done_a), 32'h0);
    chk("rs_addr", 32'(ifa.mem_addr), 32'h200);
    chk("rs_wc", 32'(word_count_a), 32'h0);
    chk("rs_txdata_kept", 32'(ifa.tx_data), 32'h06);

    // Timeout discard, exact-boundary acceptance, and ACK held off by tx_ready
    exp_mem_a.push_back({16'h0200, 16'h5678});
    exp_mem_a.push_back({16'h0202, 16'h9ABC});
    exp_tx_a.push_back(8'h06);
    send_byte(0, 8'h12);
    idle(T + 10);
    send_byte(0, 8'h56); send_byte(0, 8'h78);
    send_byte(0, 8'h9A);
    idle(T - 1);
    send_byte(0, 8'hBC);
    ifa.tx_ready = 1'b0;
    tx_before = tx_seen_a;
    send_term(0, 8'hDC);
    idle(50);
    chk("t4_done_held", 32'(load_done_a), 32'h0);
    chk("t4_no_tx", 32'(tx_seen_a), 32'(tx_before));
    ifa.tx_ready = 1'b1;
    idle(5);
    chk("t4_done", 32'(load_done_a), 32'h1);
    chk("t4_one_tx", 32'(tx_seen_a), 32'(tx_before + 1));
    chk("t4_wc", 32'(word_count_a), 32'd2);

    // Overflow on the 4-bit instance
    exp_mem_b.push_back({16'h000C, 16'h1111});
    exp_mem_b.push_back({16'h000E, 16'h2222});
    exp_tx_b.push_back(8'h15);
    send_byte(1, 8'h11); send_byte(1, 8'h11);
    send_byte(1, 8'h22); send_byte(1, 8'h22);
    send_byte(1, 8'h33); send_byte(1, 8'h33);
    idle(10);
    chk("ov_err", 32'(load_err_b), 32'h1);
    chk("ov_done", 32'(load_done_b), 32'h0);
    chk("ov_wc", 32'(word_count_b), 32'd2);
    chk("ov_addr", 32'(ifb.mem_addr), 32'hE);
    chk("ov_one_nak", 32'(tx_seen_b), 32'd1);
    restart_b = 1'b1;
    idle(1);
    restart_b = 1'b0;
    chk("ov_rs_addr", 32'(ifb.mem_addr), 32'hC);
    chk("ov_rs_err", 32'(load_err_b), 32'h0);
    chk("ov_rs_wc", 32'(word_count_b), 32'h0);

`ifdef LOADER_CHECKSUM_EN
    pulse_restart_a(8'h00);
    exp_mem_a.push_back({16'h0200, 16'h0102});
    exp_tx_a.push_back(8'h06);
    send_byte(0, 8'h01); send_byte(0, 8'h02);
    send_term(0, 8'hFD);
    idle(5);
    chk("cs_good_done", 32'(load_done_a), 32'h1);
    chk("cs_good_err", 32'(load_err_a), 32'h0);
    pulse_restart_a(8'h00);
    exp_mem_a.push_back({16'h0200, 16'h0102});
    exp_tx_a.push_back(8'h15);
    send_byte(0, 8'h01); send_byte(0, 8'h02);
    send_term(0, 8'hFC);
    idle(5);
    chk("cs_bad_done", 32'(load_done_a), 32'h0);
    chk("cs_bad_err", 32'(load_err_a), 32'h1);
`endif

    idle(5);
    chk("q_mem_a", 32'(exp_mem_a.size()), 32'd0);
    chk("q_mem_b", 32'(exp_mem_b.size()), 32'd0);
    chk("q_tx_a", 32'(exp_tx_a.size()), 32'd0);
    chk("q_tx_b", 32'(exp_tx_b.size()), 32'd0);
    chk("q_word_a", 32'(exp_word_a.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
